mem_burst_scheduler: RTL

- Decides which tracking FIFO the cell-RAM memory sequencer services next, and with what burst length.
- Serves 8 channels: 4 write-side (EP2/ADC FIFOs draining into RAM) and 4 read-side (RAM filling DAC/EP6 FIFOs).
- Watches per-channel FIFO byte counts, applies round-robin priority and issues one burst grant at a time over a valid/ready handshake.
- Holds that grant until the sequencer reports the burst done.

---
 rtl/mem_burst_scheduler.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mem_burst_scheduler.sv
// +----------------------------------------------------------------------------+
// | mem_burst_scheduler                                                        |
// | Round-robin burst grant arbiter for the cell-RAM sequencer's tracking      |
// | FIFOs.                                                                     |
// | Optional: define SCHED_WATCHDOG_EN for the BUSY-state watchdog.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_burst_scheduler #(
  parameter int NUM_CH      = 8,
  parameter int COUNT_WIDTH = 11,
  parameter int FIFO_DEPTH  = 2048,
  parameter int BURST_LEN   = 32,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CH*COUNT_WIDTH-1:0] fifo_byte_counts,
  input  logic [NUM_CH-1:0]           chan_enable,
  input  logic [NUM_CH-1:0]           chan_flush,
  output logic                        grant_valid,
  input  logic                        grant_ready,
  output logic [$clog2(NUM_CH)-1:0]   grant_chan,
  output logic                        grant_dir,
  output logic [COUNT_WIDTH-1:0]      grant_len,
  input  logic                        burst_done,
  output logic                        busy,
  output logic                        wdog_error
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [COUNT_WIDTH-1:0] C_BURST = COUNT_WIDTH'(BURST_LEN);
  localparam logic [COUNT_WIDTH:0]   C_MAX   = (COUNT_WIDTH+1)'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  state_t                 r_state;
  logic [CH_W-1:0]        r_rr_ptr;
  logic                   r_grant_valid;
  logic [CH_W-1:0]        r_grant_chan;
  logic                   r_grant_dir;
  logic [COUNT_WIDTH-1:0] r_grant_len;
  logic                   r_busy;

  logic [NUM_CH-1:0]      w_elig;
  logic [NUM_CH-1:0]      w_is_wr;
  logic [COUNT_WIDTH-1:0] w_len [NUM_CH];
  logic                   w_any;
  logic [CH_W-1:0]        w_sel;
  logic [CH_W-1:0]        w_next_ptr;

  generate
    if ((BURST_LEN > FIFO_DEPTH - 1) || (WDOG_CYCLES < 1)) begin : g_param_check
      $error("mem_burst_scheduler: BURST_LEN must be <= FIFO_DEPTH-1 and WDOG_CYCLES >= 1");
    end
  endgenerate

  // Per-channel eligibility and burst length from the live byte counts.
  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [COUNT_WIDTH-1:0] w_cnt;
      assign w_cnt = fifo_byte_counts[i*COUNT_WIDTH +: COUNT_WIDTH];

      if (i < NUM_CH/2) begin : g_wr
        assign w_is_wr[i] = 1'b1;
        assign w_elig[i]  = chan_enable[i] &&
                            ((w_cnt >= C_BURST) || (chan_flush[i] && (w_cnt != '0)));
        assign w_len[i]   = (w_cnt >= C_BURST) ? C_BURST : w_cnt;
      end else begin : g_rd
        logic [COUNT_WIDTH:0] w_free;
        assign w_free     = ({1'b0, w_cnt} > C_MAX) ? '0 : (C_MAX - {1'b0, w_cnt});
        assign w_is_wr[i] = 1'b0;
        assign w_elig[i]  = chan_enable[i] && (w_free >= {1'b0, C_BURST});
        assign w_len[i]   = C_BURST;
      end
    end
  endgenerate

  // Flush only has meaning on the write side.
  logic w_unused_flush;
  assign w_unused_flush = ^chan_flush[NUM_CH-1:NUM_CH/2];

  // Scan from the far end so the last hit written is the nearest to rr_ptr.
  always_comb begin
    logic [CH_W-1:0] idx;
    w_any = 1'b0;
    w_sel = '0;
    idx   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = CH_W'((int'(r_rr_ptr) + k) % NUM_CH);
      if (w_elig[idx]) begin
        w_any = 1'b1;
        w_sel = idx;
      end
    end
  end

  assign w_next_ptr = CH_W'((int'(r_grant_chan) + 1) % NUM_CH);

`ifdef SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] C_WDOG_LAST = WD_W'(WDOG_CYCLES - 1);
  logic [WD_W-1:0] r_wdog_cnt;
  logic            r_wdog_error;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_grant_valid <= 1'b0;
      r_grant_chan  <= '0;
      r_grant_dir   <= 1'b0;
      r_grant_len   <= '0;
      r_busy        <= 1'b0;
`ifdef SCHED_WATCHDOG_EN
      r_wdog_cnt    <= '0;
      r_wdog_error  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant_chan  <= w_sel;
            r_grant_dir   <= w_is_wr[w_sel];
            r_grant_len   <= w_len[w_sel];
            r_grant_valid <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (grant_ready) begin
            r_grant_valid <= 1'b0;
            r_state       <= S_BUSY;
`ifdef SCHED_WATCHDOG_EN
            r_wdog_cnt    <= '0;
`endif
          end
        end
        S_BUSY: begin
          if (burst_done) begin
            r_rr_ptr <= w_next_ptr;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end
`ifdef SCHED_WATCHDOG_EN
          // A hung burst is abandoned and the channel skipped next time round.
          else if (r_wdog_cnt == C_WDOG_LAST) begin
            r_wdog_error <= 1'b1;
            r_rr_ptr     <= w_next_ptr;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_wdog_cnt <= r_wdog_cnt + 1'b1;
          end
`endif
        end
        default: begin
          r_state       <= S_IDLE;
          r_grant_valid <= 1'b0;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  assign grant_valid = r_grant_valid;
  assign grant_chan  = r_grant_chan;
  assign grant_dir   = r_grant_dir;
  assign grant_len   = r_grant_len;
  assign busy        = r_busy;

`ifdef SCHED_WATCHDOG_EN
  assign wdog_error = r_wdog_error;
`else
  assign wdog_error = 1'b0;
`endif

endmodule

`default_nettype wire
